// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman driver and engine:
// FSM states, base codes, scoring constants and default geometry.
package sw_pkg;

  localparam int REF_LEN_DEF         = 64;
  localparam int QUERY_LEN_DEF       = 48;
  localparam int WIDTH_SCORE_DEF     = 8;
  localparam int WIDTH_POS_REF_DEF   = 7;
  localparam int WIDTH_POS_QUERY_DEF = 6;
  localparam int TIMEOUT_DEF         = 4096;

  // Host write address width; fixed by the host port.
  localparam int ADDR_W = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  localparam int signed SCORE_MATCH    = 2;
  localparam int signed SCORE_MISMATCH = -1;
  localparam int signed SCORE_GAP_OPEN = -2;
  localparam int signed SCORE_GAP_EXT  = -1;

endpackage

// File: rtl/sw_seq_buf.sv
// 2-bit base register file: one host write port, one read port indexed by send count.
// Out-of-range reads return 0 and out-of-range writes are dropped.
module sw_seq_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  localparam int            IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  logic [1:0] mem [DEPTH];
  logic       wr_ok;

  assign wr_ok = we && (waddr < LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  // A write landing in the same cycle as a start is forwarded to the first read.
  always_comb begin
    rdata = '0;
    if (raddr < LIMIT) rdata = mem[raddr[IW-1:0]];
    if (wr_ok && (waddr == raddr)) rdata = wdata;
  end

endmodule

// File: rtl/sw_seq_driver.sv
// Host-side feeder for the Smith-Waterman engine: buffers ref/query, streams them
// on start, then captures the engine result or flags a watchdog timeout.
module sw_seq_driver
  import sw_pkg::*;
#(
  parameter int REF_LEN         = REF_LEN_DEF,
  parameter int QUERY_LEN       = QUERY_LEN_DEF,
  parameter int WIDTH_SCORE     = WIDTH_SCORE_DEF,
  parameter int WIDTH_POS_REF   = WIDTH_POS_REF_DEF,
  parameter int WIDTH_POS_QUERY = WIDTH_POS_QUERY_DEF,
  parameter int TIMEOUT         = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [1:0]                 wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [WIDTH_SCORE-1:0]     result_max,
  output logic [WIDTH_POS_REF-1:0]   result_pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] result_pos_query,
  output logic                       sw_valid,
  output logic [1:0]                 sw_data_ref,
  output logic [1:0]                 sw_data_query,
  input  logic                       sw_finish,
  input  logic [WIDTH_SCORE-1:0]     sw_max,
  input  logic [WIDTH_POS_REF-1:0]   sw_pos_ref,
  input  logic [WIDTH_POS_QUERY-1:0] sw_pos_query
);

  localparam int                WDW      = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]    WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] SEND_END = ADDR_W'(REF_LEN);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [WDW-1:0]    wd;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        ref_rd;
  logic [1:0]        qry_rd;
  logic              host_ok;

  assign host_ok = (state == S_IDLE) || (state == S_DONE);
  // Outside SEND the read port sits on base 0 so a start can register it directly.
  assign rd_addr = (state == S_SEND) ? cnt : '0;

  sw_seq_buf #(.DEPTH(REF_LEN), .AW(ADDR_W)) u_ref_buf (
    .clk   (clk),
    .reset (reset),
    .we    (host_ok && wr_en && !wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (ref_rd)
  );

  sw_seq_buf #(.DEPTH(QUERY_LEN), .AW(ADDR_W)) u_qry_buf (
    .clk   (clk),
    .reset (reset),
    .we    (host_ok && wr_en && wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (qry_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      wd               <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout          <= 1'b0;
      result_max       <= '0;
      result_pos_ref   <= '0;
      result_pos_query <= '0;
      sw_valid         <= 1'b0;
      sw_data_ref      <= '0;
      sw_data_query    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state            <= S_SEND;
            busy             <= 1'b1;
            done             <= 1'b0;
            timeout          <= 1'b0;
            result_max       <= '0;
            result_pos_ref   <= '0;
            result_pos_query <= '0;
            sw_valid         <= 1'b1;
            sw_data_ref      <= ref_rd;
            sw_data_query    <= qry_rd;
            cnt              <= ADDR_W'(1);
          end
        end
        S_SEND: begin
          if (cnt == SEND_END) begin
            state         <= S_WAIT;
            sw_valid      <= 1'b0;
            sw_data_ref   <= '0;
            sw_data_query <= '0;
            wd            <= '0;
          end else begin
            sw_data_ref   <= ref_rd;
            sw_data_query <= qry_rd;
            cnt           <= cnt + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          // Finish takes priority over the watchdog threshold.
          if (sw_finish) begin
            state            <= S_DONE;
            busy             <= 1'b0;
            done             <= 1'b1;
            timeout          <= 1'b0;
            result_max       <= sw_max;
            result_pos_ref   <= sw_pos_ref;
            result_pos_query <= sw_pos_query;
          end else if (wd == WD_LAST) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
